seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The module SHALL have parameter PAT_W, default 8, meaning maximum pattern length in bits (legal range 2..32).
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning width of the saturating match counter.
REQ-003 The module SHALL have parameter LEN_W, default $clog2(PAT_W+1), meaning width of pat_len.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port data_valid, input, 1 bit: data_in is sampled only when this is 1.
REQ-007 The module SHALL have port data_in, input, 1 bit: the serial bit stream.
REQ-008 The module SHALL have port cfg_load, input, 1 bit: latches pattern, pat_len and overlap_en on the rising edge.
REQ-009 The module SHALL have port pattern, input, PAT_W bits. The first-received bit is pattern[pat_len-1] and the last is pattern[0].
REQ-010 The module SHALL have port pat_len, input, LEN_W bits: the active pattern length.
REQ-011 The module SHALL have port overlap_en, input, 1 bit. When 1, overlapping matches are counted; when 0, the search restarts after each match.
REQ-012 The module SHALL have port match, output, 1 bit: Moore output, 1 exactly while the state is MATCH.
REQ-013 The module SHALL have port match_count, output, CNT_W bits: the saturating count of matches.
REQ-014 The module SHALL have port cnt_sat, output, 1 bit: 1 once match_count reaches its maximum value.
REQ-015 The module SHALL have port cfg_err, output, 1 bit: 1 while the latched pat_len is illegal.
REQ-016 The module SHALL have port ready, output, 1 bit: 1 when the state is SEARCH or MATCH.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SEARCH and MATCH, held in a state register; match and ready SHALL be decoded from that register only.
REQ-018 In IDLE, a cfg_load with legal pat_len (2..PAT_W) SHALL move the FSM to SEARCH, clear the history and the fill count, and clear cfg_err.
REQ-019 A cfg_load with pat_len 0, 1 or greater than PAT_W SHALL set cfg_err and SHALL move the FSM to IDLE from any state.
REQ-020 A cfg_load in SEARCH or MATCH SHALL flush the history and fill count, reload the configuration, enter SEARCH, and leave match_count unchanged.
REQ-021 On each edge with data_valid=1 in SEARCH or MATCH, data_in SHALL shift into the PAT_W-bit history at the LSB, and the fill count SHALL increment, saturating at PAT_W.
REQ-022 A match SHALL occur when the low pat_len bits of the updated history equal the low pat_len bits of the latched pattern and the updated fill count is at least pat_len.
REQ-023 When a match occurs, the next state SHALL be MATCH, so match is high in the cycle immediately after the edge that sampled the final bit (latency 1).
REQ-024 From MATCH, the FSM SHALL return to SEARCH unless the current edge produces another match; back-to-back matches keep match high.
REQ-025 When overlap_en=0, a match SHALL clear the fill count, so the next match requires pat_len fresh valid bits.
REQ-026 Cycles with data_valid=0 SHALL hold the history and fill count, and SHALL leave MATCH for SEARCH; bubbles never break a partial sequence.
REQ-027 match_count SHALL increment by 1 on each edge entering or re-entering MATCH, SHALL saturate at 2^CNT_W-1, and SHALL assert cnt_sat on reaching that value.
REQ-028 If cfg_load and data_valid are asserted on the same edge, cfg_load SHALL take priority and data_in SHALL be discarded.

Reset
REQ-029 When reset=0, the module SHALL immediately and asynchronously force: state IDLE, match 0, ready 0, match_count 0, cnt_sat 0, cfg_err 0, history 0, fill count 0, latched configuration 0.
REQ-030 After reset deasserts, the block SHALL remain in IDLE until a legal cfg_load; reset asserted mid-sequence SHALL discard all partial progress.

Structure
REQ-031 The state encoding (IDLE=2'b00, SEARCH=2'b01, MATCH=2'b10) and the legal pat_len bounds SHALL live in the shared package seq_det_pkg.
REQ-032 The masked history/pattern comparator SHALL be the sub-module seq_det_cmp; all other logic SHALL stay in seq_detector_param.

Verification
REQ-033 The bench SHALL cover reset held low with random inputs -> match=0, ready=0, match_count=0 throughout.
REQ-034 The bench SHALL cover pattern=6'b111011, pat_len=6, overlap_en=0, stream 1,1,1,0,1,1 -> match=1 for exactly one cycle after the 6th bit; match_count=1.
REQ-035 The bench SHALL cover pattern=3'b101, pat_len=3, stream 1,0,1,0,1: with overlap_en=1 -> matches after bits 3 and 5, count 2; with overlap_en=0 -> one match only, count 1.
REQ-036 The bench SHALL cover stream 1,1,1,0,1,1 with data_valid=0 bubbles between bits -> one match after the last valid bit; no match during bubbles.
REQ-037 The bench SHALL cover CNT_W=2 with 5 matches -> match_count=3 and cnt_sat=1.
REQ-038 The bench SHALL cover cfg_load with pat_len=0 -> cfg_err=1, state IDLE, no matches; and cfg_load after three valid bits of a six-bit pattern -> those bits are discarded.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: state encoding and
// the legal bounds on the active pattern length.
package seq_det_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SEARCH = 2'b01;
    localparam logic [1:0] ST_MATCH  = 2'b10;

    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 32;

    // A pattern length is usable when it is at least PAT_LEN_MIN and fits the
    // instantiated history width.
    function automatic logic len_legal(input int len, input int max_len);
        return (len >= PAT_LEN_MIN) && (len <= max_len) && (len <= PAT_LEN_MAX);
    endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked comparator: compares only the low pat_len bits of the history
// against the latched pattern.
module seq_det_cmp #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic [PAT_W-1:0] hist,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    output logic             eq
);

    logic [PAT_W-1:0] mask;

    // Build a thermometer mask covering bits [pat_len-1:0].
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(pat_len));
        end
    end

    assign eq = ~|((hist ^ pattern) & mask);

endmodule

// File: rtl/seq_detector_param.sv
// Configurable serial sequence detector with overlap control and a
// saturating match counter.
//
// state  | meaning
// IDLE   | no legal configuration loaded; input stream ignored
// SEARCH | collecting bits, no match on the most recent edge
// MATCH  | the most recent edge completed a pattern occurrence
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_valid,
    input  logic             data_in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat,
    output logic             cfg_err,
    output logic             ready
);

    logic [1:0]       state;
    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] count;
    logic             err_q;

    logic [PAT_W-1:0] hist_nxt;
    logic [LEN_W-1:0] fill_nxt;
    logic             cmp_eq;
    logic             hit;
    logic             active;
    logic             len_ok;

    // Candidate history/fill for a valid bit; fill saturates at PAT_W.
    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], data_in};
        fill_nxt = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    end

    seq_det_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .hist    (hist_nxt),
        .pattern (pat_q),
        .pat_len (len_q),
        .eq      (cmp_eq)
    );

    assign hit    = cmp_eq && (fill_nxt >= len_q);
    assign active = (state == ST_SEARCH) || (state == ST_MATCH);
    assign len_ok = len_legal(int'(pat_len), PAT_W);

    // FSM, history, configuration and counter; cfg_load outranks data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            hist  <= '0;
            fill  <= '0;
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b0;
            count <= '0;
            err_q <= 1'b0;
        end else if (cfg_load) begin
            pat_q <= pattern;
            len_q <= pat_len;
            ovl_q <= overlap_en;
            hist  <= '0;
            fill  <= '0;
            if (len_ok) begin
                state <= ST_SEARCH;
                err_q <= 1'b0;
            end else begin
                state <= ST_IDLE;
                err_q <= 1'b1;
            end
        end else if (active) begin
            if (data_valid) begin
                hist <= hist_nxt;
                if (hit) begin
                    state <= ST_MATCH;
                    fill  <= ovl_q ? fill_nxt : '0;
                    if (count != {CNT_W{1'b1}}) begin
                        count <= count + 1'b1;
                    end
                end else begin
                    state <= ST_SEARCH;
                    fill  <= fill_nxt;
                end
            end else begin
                state <= ST_SEARCH;
            end
        end
    end

    assign match       = (state == ST_MATCH);
    assign ready       = (state == ST_SEARCH) || (state == ST_MATCH);
    assign match_count = count;
    assign cnt_sat     = &count;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: the stimulus side pushes the expected post-edge outputs
// from a bit-list reference model; a monitor pops and compares after each edge.
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             data_valid = 1'b0;
    logic             data_in = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [LEN_W-1:0] pat_len = '0;
    logic             overlap_en = 1'b0;

    logic       match_a, cnt_sat_a, cfg_err_a, ready_a;
    logic [7:0] count_a;
    logic       match_b, cnt_sat_b, cfg_err_b, ready_b;
    logic [1:0] count_b;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(8), .LEN_W(LEN_W)) dut_a (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
        .overlap_en(overlap_en), .match(match_a), .match_count(count_a),
        .cnt_sat(cnt_sat_a), .cfg_err(cfg_err_a), .ready(ready_a)
    );

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(2), .LEN_W(LEN_W)) dut_b (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
        .overlap_en(overlap_en), .match(match_b), .match_count(count_b),
        .cnt_sat(cnt_sat_b), .cfg_err(cfg_err_b), .ready(ready_b)
    );

    typedef struct {
        logic       match;
        logic       ready;
        logic       err;
        logic [7:0] c8;
        logic       s8;
        logic [1:0] c2;
        logic       s2;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: the bits received since the last flush.
    bit         m_cfg_ok = 0;
    bit         m_in_match = 0;
    bit         m_err = 0;
    bit [7:0]   m_pat = '0;
    int         m_len = 0;
    bit         m_ovl = 0;
    int         m_c8 = 0;
    int         m_c2 = 0;
    bit         m_bits[$];

    task automatic step(input logic r, input logic cl, input logic [7:0] p,
                        input int l, input logic o, input logic v, input logic d);
        exp_t e;
        bit   hit;
        @(negedge clk);
        reset = r; cfg_load = cl; pattern = p; pat_len = LEN_W'(l);
        overlap_en = o; data_valid = v; data_in = d;
        if (!r) begin
            m_cfg_ok = 0; m_in_match = 0; m_err = 0; m_pat = '0; m_len = 0;
            m_ovl = 0; m_c8 = 0; m_c2 = 0; m_bits.delete();
        end else if (cl) begin
            m_pat = p; m_len = l; m_ovl = o; m_bits.delete(); m_in_match = 0;
            if (l >= 2 && l <= PAT_W) begin
                m_cfg_ok = 1; m_err = 0;
            end else begin
                m_cfg_ok = 0; m_err = 1;
            end
        end else if (m_cfg_ok) begin
            if (v) begin
                m_bits.push_back(d);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                hit = (m_bits.size() >= m_len);
                for (int i = 0; i < m_len; i++) begin
                    if (hit && m_bits[m_bits.size() - m_len + i] != m_pat[m_len - 1 - i])
                        hit = 0;
                end
                m_in_match = hit;
                if (hit) begin
                    if (m_c8 < 255) m_c8++;
                    if (m_c2 < 3) m_c2++;
                    if (!m_ovl) m_bits.delete();
                end
            end else begin
                m_in_match = 0;
            end
        end
        e.match = m_in_match;
        e.ready = m_cfg_ok;
        e.err   = m_err;
        e.c8    = 8'(m_c8);
        e.s8    = (m_c8 == 255);
        e.c2    = 2'(m_c2);
        e.s2    = (m_c2 == 3);
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1, 0, pattern, int'(pat_len), overlap_en, 1, bits[i]);
            for (int g = 0; g < gap; g++)
                step(1, 0, pattern, int'(pat_len), overlap_en, 0, $urandom_range(0, 1));
        end
    endtask

    task automatic load(input logic [7:0] p, input int l, input logic o);
        step(1, 1, p, l, o, $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, 0, 0, 0);
        step(1, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: one expected record per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("match_a", 8'(match_a), 8'(e.match));
                chk("ready_a", 8'(ready_a), 8'(e.ready));
                chk("cfg_err_a", 8'(cfg_err_a), 8'(e.err));
                chk("count_a", count_a, e.c8);
                chk("cnt_sat_a", 8'(cnt_sat_a), 8'(e.s8));
                chk("match_b", 8'(match_b), 8'(e.match));
                chk("ready_b", 8'(ready_b), 8'(e.ready));
                chk("count_b", 8'(count_b), 8'(e.c2));
                chk("cnt_sat_b", 8'(cnt_sat_b), 8'(e.s2));
            end
        end
    end

    initial begin
        int budget;
        // Reset held low with random inputs.
        for (int i = 0; i < 12; i++)
            step(0, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 9),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        step(1, 0, '0, 0, 0, 1, 1);

        // Six-bit pattern, no overlap.
        load(8'b0011_1011, 6, 0);
        send_bits(8'b0011_1011, 6, 0);
        step(1, 0, pattern, 6, 0, 0, 0);

        // 101 with overlap, then without.
        do_reset();
        load(8'b0000_0101, 3, 1);
        send_bits(8'b0001_0101, 5, 0);
        do_reset();
        load(8'b0000_0101, 3, 0);
        send_bits(8'b0001_0101, 5, 0);

        // Bubbles between bits.
        do_reset();
        load(8'b0011_1011, 6, 0);
        send_bits(8'b0011_1011, 6, 2);

        // Saturation of the two-bit counter: "11" with overlap, six ones.
        do_reset();
        load(8'b0000_0011, 2, 1);
        send_bits(8'b0011_1111, 6, 0);

        // Illegal length, then a reload that discards partial progress.
        do_reset();
        load(8'b0011_1011, 0, 0);
        send_bits(8'b0011_1011, 6, 0);
        load(8'b0011_1011, 9, 0);
        load(8'b0011_1011, 6, 0);
        send_bits(8'b0000_0111, 3, 0);
        load(8'b0011_1011, 6, 0);
        send_bits(8'b0000_0011, 2, 0);
        send_bits(8'b0011_1011, 6, 0);

        // Mid-sequence reset.
        send_bits(8'b0000_0111, 3, 0);
        do_reset();
        send_bits(8'b0000_0011, 3, 0);

        // Randomised traffic favouring short patterns.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3)
                step(0, 0, '0, 0, 0, 0, 0);
            else if (r < 20)
                load(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9)
                                                                : $urandom_range(2, 4),
                     $urandom_range(0, 1));
            else
                step(1, 0, pattern, int'(pat_len), overlap_en,
                     ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
